// File: rtl/rmw_unit.sv
// rmw_unit: single-outstanding read-modify-write engine for partial stores.
// Optional feature macro: RMW_FULL_MASK_BYPASS_EN (full-mask stores skip the read).

module mask_filter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] result
);
    assign result = data & mask;
endmodule

module rmw_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_data,
    input  logic [WIDTH-1:0]      req_mask,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack
);

`ifdef RMW_FULL_MASK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] new_bits;
    logic [WIDTH-1:0] kept_bits;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] keep_mask;
    logic             mask_zero;
    logic             mask_full;

    assign keep_mask = ~mask_q;
    assign mask_zero = (req_mask == '0);
    assign mask_full = &req_mask;

    mask_filter #(.WIDTH(WIDTH)) u_new (
        .data   (data_q),
        .mask   (mask_q),
        .result (new_bits)
    );

    mask_filter #(.WIDTH(WIDTH)) u_kept (
        .data   (mem_rdata),
        .mask   (keep_mask),
        .result (kept_bits)
    );

    assign merged = new_bits | kept_bits;

    // ready is decoded from state, masked so it stays low during reset
    assign req_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_q    <= '0;
            mask_q    <= '0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (req_valid) begin
                        data_q   <= req_data;
                        mask_q   <= req_mask;
                        mem_addr <= req_addr;
                        if (mask_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (BYPASS && mask_full) begin
                            state     <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= req_data;
                        end else begin
                            state  <= READ;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        state     <= WRITE;
                        mem_rd    <= 1'b0;
                        mem_wr    <= 1'b1;
                        mem_wdata <= merged;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state  <= DONE;
                        mem_wr <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmw_unit.sv
// Self-checking bench for rmw_unit with a behavioural memory and merge model.
// Build with RMW_FULL_MASK_BYPASS_EN to exercise the full-mask bypass.

module tb_rmw_unit;

    localparam int W  = 32;
    localparam int AW = 16;

`ifdef RMW_FULL_MASK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [W-1:0]  req_data  = '0;
    logic [W-1:0]  req_mask  = '0;
    logic          req_ready;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata = '0;
    logic          mem_ack   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int wcnt    = 0;
    bit stray   = 1'b0;

    logic [W-1:0] mem [logic [AW-1:0]];

    typedef struct {
        int           first_rd;
        int           first_wr;
        int           done_cyc;
        int           rd_n;
        int           wr_n;
        int           ready_back;
        logic [W-1:0] wdata;
        bit           moved;
        bit           overlap;
        bit           ready_early;
        bit           addr_bad;
    } obs_t;

    rmw_unit #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rd_mem(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    // per-bit merge: a mask bit of 1 takes new data, 0 keeps the old bit
    function automatic logic [W-1:0] exp_merge(input logic [W-1:0] old,
                                               input logic [W-1:0] d,
                                               input logic [W-1:0] m);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = m[i] ? d[i] : old[i];
        return r;
    endfunction

    // completion cycle from the latency rules; l = wait cycles per access
    function automatic int exp_done(input logic [W-1:0] m, input int l);
        if (m == '0) return 1;
        if (BYPASS && (&m)) return 2 + l;
        return 3 + 2 * l;
    endfunction

    // memory responder: ack after lat wait cycles; garbage rdata otherwise
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_rd || mem_wr) begin
            if (wcnt >= lat) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_rd) mem_rdata = rd_mem(mem_addr);
                else mem[mem_addr] = mem_wdata;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        if (stray) mem_ack = 1'b1;
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] m, input int l, output obs_t o);
        o = '{first_rd: -1, first_wr: -1, done_cyc: -1, rd_n: 0, wr_n: 0,
              ready_back: -1, wdata: '0, moved: 0, overlap: 0,
              ready_early: 0, addr_bad: 0};
        lat = l;
        @(negedge clk);
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_data  = $urandom;
        req_mask  = $urandom;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (o.done_cyc >= 0) begin
                o.ready_back = req_ready ? c : -1;
                break;
            end
            if (mem_rd) begin
                if (o.first_rd < 0) o.first_rd = c;
                o.rd_n++;
                if (mem_addr !== a) o.addr_bad = 1;
            end
            if (mem_wr) begin
                if (o.first_wr < 0) o.wdata = mem_wdata;
                else if (mem_wdata !== o.wdata) o.moved = 1;
                if (o.first_wr < 0) o.first_wr = c;
                o.wr_n++;
                if (mem_addr !== a) o.addr_bad = 1;
            end
            if (mem_rd && mem_wr) o.overlap = 1;
            if (req_ready) o.ready_early = 1;
            if (done) o.done_cyc = c;
        end
        lat = 0;
    endtask

    task automatic test_reset();
        logic bad;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({req_ready, done, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got rdy=%b done=%b rd=%b wr=%b addr=%h wd=%h, want all 0",
                     req_ready, done, mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
        mem[16'h0010] = 32'h5555aaaa;
        lat = 50;
        req_addr  = 16'h0010;
        req_data  = 32'h11111111;
        req_mask  = 32'h0000ff00;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_read: mem_rd got %b want 1", mem_rd);
        end
        @(negedge clk);
        rst_n = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_rd !== 1'b0 || req_ready !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_mid_read: strobe/ready/done got 1 during reset, want 0");
        end
        rst_n = 1'b1;
        lat = 0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (req_ready !== 1'b1 || done !== 1'b0 || mem_rd !== 1'b0 ||
                mem_wr !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_after: rdy=%b done=%b rd=%b wr=%b addr=%h wd=%h, want rdy=1 rest 0",
                     req_ready, done, mem_rd, mem_wr, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_partial_merge();
        obs_t o;
        logic [W-1:0] exp;
        mem[16'h0040] = 32'hffffffff;
        exp = exp_merge(32'hffffffff, 32'h12312312, 32'h50f37431);
        do_req(16'h0040, 32'h12312312, 32'h50f37431, 0, o);
        n_tests++;
        if (o.first_rd !== 1 || o.first_wr !== 2 || o.done_cyc !== 3 || o.ready_back !== 4) begin
            n_fail++;
            $display("FAIL partial_timing: rd=%0d wr=%0d done=%0d rdy=%0d want 1 2 3 4",
                     o.first_rd, o.first_wr, o.done_cyc, o.ready_back);
        end
        n_tests++;
        if (o.wdata !== exp) begin
            n_fail++;
            $display("FAIL partial_wdata: got %h want %h", o.wdata, exp);
        end
        n_tests++;
        if (rd_mem(16'h0040) !== exp || o.addr_bad || o.ready_early) begin
            n_fail++;
            $display("FAIL partial_mem: mem=%h want %h addr_bad=%b rdy_early=%b",
                     rd_mem(16'h0040), exp, o.addr_bad, o.ready_early);
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        logic [W-1:0] exp;
        mem[16'h0040] = 32'hffffffff;
        exp = exp_merge(32'hffffffff, 32'h12312312, 32'h50f37431);
        do_req(16'h0040, 32'h12312312, 32'h50f37431, 2, o);
        n_tests++;
        if (o.rd_n !== 3 || o.wr_n !== 3 || o.first_wr !== 4 || o.done_cyc !== 7) begin
            n_fail++;
            $display("FAIL wait_timing: rd_n=%0d wr_n=%0d wr@%0d done@%0d want 3 3 4 7",
                     o.rd_n, o.wr_n, o.first_wr, o.done_cyc);
        end
        n_tests++;
        if (o.moved || o.wdata !== exp) begin
            n_fail++;
            $display("FAIL wait_wdata: got %h moved=%b want %h stable", o.wdata, o.moved, exp);
        end
    endtask

    task automatic test_zero_mask();
        obs_t o;
        mem[16'h0080] = 32'h13579bdf;
        do_req(16'h0080, 32'hdeadbeef, 32'h00000000, 0, o);
        n_tests++;
        if (o.rd_n !== 0 || o.wr_n !== 0 || o.done_cyc !== 1 || o.ready_back !== 2) begin
            n_fail++;
            $display("FAIL zero_mask: rd_n=%0d wr_n=%0d done@%0d rdy@%0d want 0 0 1 2",
                     o.rd_n, o.wr_n, o.done_cyc, o.ready_back);
        end
        n_tests++;
        if (rd_mem(16'h0080) !== 32'h13579bdf) begin
            n_fail++;
            $display("FAIL zero_mask_mem: got %h want 13579bdf", rd_mem(16'h0080));
        end
    endtask

    task automatic test_full_mask();
        obs_t o;
        mem[16'h00c0] = 32'h00000000;
        do_req(16'h00c0, 32'hcafef00d, 32'hffffffff, 0, o);
        n_tests++;
        if (BYPASS) begin
            if (o.rd_n !== 0 || o.first_wr !== 1 || o.done_cyc !== 2) begin
                n_fail++;
                $display("FAIL full_bypass: rd_n=%0d wr@%0d done@%0d want 0 1 2",
                         o.rd_n, o.first_wr, o.done_cyc);
            end
        end else begin
            if (o.rd_n !== 1 || o.first_wr !== 2 || o.done_cyc !== 3) begin
                n_fail++;
                $display("FAIL full_normal: rd_n=%0d wr@%0d done@%0d want 1 2 3",
                         o.rd_n, o.first_wr, o.done_cyc);
            end
        end
        n_tests++;
        if (o.wdata !== 32'hcafef00d || rd_mem(16'h00c0) !== 32'hcafef00d) begin
            n_fail++;
            $display("FAIL full_wdata: got %h mem %h want cafef00d", o.wdata, rd_mem(16'h00c0));
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [AW-1:0] a;
        logic [W-1:0]  d, m, old, exp;
        int l, sel;
        for (int i = 0; i < 30; i++) begin
            a   = AW'($urandom_range(0, 15));
            d   = $urandom;
            sel = $urandom_range(0, 5);
            m   = (sel == 0) ? '0 : (sel == 1) ? '1 : $urandom;
            l   = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) mem[a] = $urandom;
            old = rd_mem(a);
            exp = exp_merge(old, d, m);
            do_req(a, d, m, l, o);
            n_tests++;
            if (o.done_cyc !== exp_done(m, l)) begin
                n_fail++;
                $display("FAIL rand_done[%0d]: got %0d want %0d (m=%h l=%0d)",
                         i, o.done_cyc, exp_done(m, l), m, l);
            end
            n_tests++;
            if (rd_mem(a) !== exp) begin
                n_fail++;
                $display("FAIL rand_mem[%0d]: got %h want %h (old=%h d=%h m=%h)",
                         i, rd_mem(a), exp, old, d, m);
            end
            n_tests++;
            if (o.overlap || o.moved || o.addr_bad || o.ready_early) begin
                n_fail++;
                $display("FAIL rand_proto[%0d]: overlap=%b moved=%b addr_bad=%b rdy_early=%b want 0",
                         i, o.overlap, o.moved, o.addr_bad, o.ready_early);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        int acc_b, rd_start_b;
        bit addr_bad, rdy_bad, b_done_wait;
        logic prev_rd;
        logic [W-1:0] exp_a, exp_b;
        mem[16'h0100] = 32'ha5a5a5a5;
        mem[16'h0104] = 32'h0f0f0f0f;
        exp_a = exp_merge(32'ha5a5a5a5, 32'h12345678, 32'h0000ffff);
        exp_b = exp_merge(32'h0f0f0f0f, 32'h89abcdef, 32'hff00ff00);
        acc_b = -1; rd_start_b = -1; addr_bad = 0; rdy_bad = 0; prev_rd = 0;
        lat = 0;
        @(negedge clk);
        req_addr = 16'h0100; req_data = 32'h12345678; req_mask = 32'h0000ffff;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 16'h0104; req_data = 32'h89abcdef; req_mask = 32'hff00ff00;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) dones.push_back(c);
            if (c <= 3 && (req_ready || (mem_addr !== 16'h0100))) rdy_bad = 1;
            if (c >= 5 && c <= 7 && mem_addr !== 16'h0104) addr_bad = 1;
            if (mem_rd && !prev_rd && acc_b >= 0 && rd_start_b < 0) rd_start_b = c;
            prev_rd = mem_rd;
            if (req_ready && req_valid) begin
                acc_b = c;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        n_tests++;
        if (acc_b !== 4 || rd_start_b !== 5) begin
            n_fail++;
            $display("FAIL b2b_accept: accept edge %0d rd@%0d want 4 5", acc_b, rd_start_b);
        end
        b_done_wait = (dones.size() != 2) || (dones.size() == 2 && (dones[0] != 3 || dones[1] != 7));
        n_tests++;
        if (b_done_wait) begin
            n_fail++;
            $display("FAIL b2b_done: got %0d done pulses first@%0d, want 2 at 3 and 7",
                     dones.size(), (dones.size() > 0) ? dones[0] : -1);
        end
        n_tests++;
        if (rdy_bad || addr_bad) begin
            n_fail++;
            $display("FAIL b2b_hold: rdy_or_addrA_bad=%b addrB_bad=%b want 0 0", rdy_bad, addr_bad);
        end
        n_tests++;
        if (rd_mem(16'h0100) !== exp_a || rd_mem(16'h0104) !== exp_b) begin
            n_fail++;
            $display("FAIL b2b_mem: got %h %h want %h %h",
                     rd_mem(16'h0100), rd_mem(16'h0104), exp_a, exp_b);
        end
        rdy_bad = 0;
        @(negedge clk);
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!req_ready || done || mem_rd || mem_wr || mem_addr !== 16'h0104 ||
                mem_wdata !== exp_b) rdy_bad = 1;
        end
        stray = 1'b0;
        n_tests++;
        if (rdy_bad) begin
            n_fail++;
            $display("FAIL stray_ack: rdy=%b done=%b rd=%b wr=%b addr=%h, want idle unchanged",
                     req_ready, done, mem_rd, mem_wr, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_partial_merge();
        test_wait_states();
        test_zero_mask();
        test_full_mask();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
